// File: rtl/dac_spi_writer.sv
// rtl/dac_spi_writer.sv - serialises 12-bit samples into 16-bit MCP4921-style SPI write frames
// Optional LDAC commit pulse is built when DAC_LDAC_PULSE_EN is defined; otherwise dac_ldac_n is tied low.
module dac_spi_writer #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  DAC_CFG = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_ldac_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
`ifdef DAC_LDAC_PULSE_EN
    , S_LDAC
`endif
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
`ifdef DAC_LDAC_PULSE_EN
  localparam logic       LDAC_IDLE = 1'b1;
`else
  localparam logic       LDAC_IDLE = 1'b0;
`endif

  state_t      state, state_n;
  logic [7:0]  phase_cnt, phase_n;
  logic [3:0]  bit_cnt, bit_n;
  logic        sclk_hi, sclk_hi_n;
  logic [15:0] shreg, shreg_n;
  logic        cs_n_d, sclk_d, mosi_d, ldac_n_d;
  logic        phase_done;

  assign phase_done   = (phase_cnt == DIV_LAST);
  assign sample_ready = (state == S_IDLE);
  assign busy         = !sample_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase_cnt  <= 8'd0;
      bit_cnt    <= 4'd0;
      sclk_hi    <= 1'b0;
      shreg      <= 16'd0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= LDAC_IDLE;
    end else begin
      state      <= state_n;
      phase_cnt  <= phase_n;
      bit_cnt    <= bit_n;
      sclk_hi    <= sclk_hi_n;
      shreg      <= shreg_n;
      dac_cs_n   <= cs_n_d;
      dac_sclk   <= sclk_d;
      dac_mosi   <= mosi_d;
      dac_ldac_n <= ldac_n_d;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase_cnt;
    bit_n     = bit_cnt;
    sclk_hi_n = sclk_hi;
    shreg_n   = shreg;
    if (state != S_IDLE) begin
      phase_n = phase_done ? 8'd0 : phase_cnt + 8'd1;
    end
    case (state)
      S_IDLE: begin
        if (sample_valid) begin
          state_n = S_SETUP;
          phase_n = 8'd0;
          shreg_n = {DAC_CFG, sample};
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          state_n   = S_SHIFT;
          bit_n     = 4'd0;
          sclk_hi_n = 1'b0;
        end
      end
      S_SHIFT: begin
        // The next bit is presented on the same edge that drops SCLK, so MOSI only moves in the low phase.
        if (phase_done) begin
          if (!sclk_hi) begin
            sclk_hi_n = 1'b1;
          end else if (bit_cnt == 4'd15) begin
            state_n   = S_HOLD;
            sclk_hi_n = 1'b0;
          end else begin
            bit_n     = bit_cnt + 4'd1;
            sclk_hi_n = 1'b0;
            shreg_n   = {shreg[14:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (phase_done) begin
`ifdef DAC_LDAC_PULSE_EN
          state_n = S_LDAC;
`else
          state_n = S_GAP;
`endif
        end
      end
`ifdef DAC_LDAC_PULSE_EN
      S_LDAC: begin
        if (phase_done) state_n = S_GAP;
      end
`endif
      S_GAP: begin
        if (phase_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they land in registers alongside it.
  always_comb begin
    cs_n_d   = 1'b1;
    sclk_d   = 1'b0;
    mosi_d   = 1'b0;
    ldac_n_d = LDAC_IDLE;
    case (state_n)
      S_SETUP, S_SHIFT, S_HOLD: begin
        cs_n_d = 1'b0;
        mosi_d = shreg_n[15];
      end
      default: ;
    endcase
    if (state_n == S_SHIFT) sclk_d = sclk_hi_n;
`ifdef DAC_LDAC_PULSE_EN
    if (state_n == S_LDAC) ldac_n_d = 1'b0;
`endif
  end

endmodule

// File: doc/dac_spi_writer.md
# dac_spi_writer

Downstream stage of the triangular wave generator. Accepts 12-bit samples over a valid/ready handshake and serialises each one as a 16-bit SPI write frame to an external 12-bit DAC (MCP4921-style framing). An optional LDAC strobe commits the value. It runs in the same 12 MHz clock domain as the sample source, and the SPI clock is derived internally.

## Interface
- `CLK_DIV`, default 2: SPI half-period in `clk` cycles; legal range 1..255 (8-bit counter); 0 is illegal. Default gives SCLK = 12 MHz / 4 = 3 MHz.
- `DAC_CFG`, default 4'b0011: frame header bits [15:12] = {A/B, BUF, GA_n, SHDN_n}; default is channel A, unbuffered, 1x gain, active.
- `clk`  in  1: system clock, 12 MHz. One clock; all logic on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sample`  in  12: DAC code, unsigned.
- `sample_valid`  in  1: `sample` is valid this cycle.
- `sample_ready`  out  1: block can accept a sample; equals (state == IDLE).
- `busy`  out  1: frame in progress; equals !sample_ready.
- `dac_cs_n`  out  1: DAC chip select, active low.
- `dac_sclk`  out  1: SPI clock, idle low (mode 0,0).
- `dac_mosi`  out  1: serial data, MSB first.
- `dac_ldac_n`  out  1: DAC latch strobe, active low.

## Operation
- **Accept:** a sample is accepted on a rising edge where `sample_valid && sample_ready`. At that edge the 16-bit shift register loads {`DAC_CFG`, `sample`}. `sample_valid` while not ready is ignored, and the sample is not queued. The producer holds `sample` and `sample_valid` until the handshake completes.
- **States:** IDLE → SETUP → SHIFT → HOLD → LDAC → GAP → IDLE. A shared half-period counter counts `CLK_DIV` cycles per phase.
- **IDLE:** `dac_cs_n` = 1, `dac_sclk` = 0, `dac_ldac_n` = 1. Transitions to SETUP on accept.
- **SETUP:** `dac_cs_n` = 0, `dac_sclk` = 0, `dac_mosi` = bit 15. Lasts `CLK_DIV` cycles.
- **SHIFT:** 16 bits.
  - Each bit is a low phase followed by a high phase, each `CLK_DIV` cycles long.
  - `dac_mosi` updates only at the start of a low phase. The DAC samples on the SCLK rising edge.
  - After the high phase of bit 0 (the LSB), `dac_sclk` returns low and the state moves to HOLD.
- **HOLD:** `dac_cs_n` = 0, `dac_sclk` = 0. Lasts `CLK_DIV` cycles, then `dac_cs_n` goes to 1.
- **LDAC:** `dac_ldac_n` = 0 for `CLK_DIV` cycles, with `dac_cs_n` = 1.
- **GAP:** all lines idle for `CLK_DIV` cycles, then the state returns to IDLE.
- **Widths:** no arithmetic on the data path. The bit counter is 4 bits and terminates at 15 with no wrap-around. The phase counter is 8 bits.
- **Mid-frame reset:** `rst_n` low forces IDLE immediately and asynchronously, and the frame is aborted. The DAC ignores a partial frame (fewer than 16 clocks before CS rises). After release, the block is ready at once.

## Timing
- **Reset values:** `dac_cs_n` = 1, `dac_sclk` = 0, `dac_mosi` = 0, `dac_ldac_n` = 1, `sample_ready` = 1, `busy` = 0.
- **Sequence from accept edge E0:**
  - `dac_cs_n` falls at E0 and stays low for 34·`CLK_DIV` cycles.
  - First SCLK rise at E0 + 2·`CLK_DIV`.
  - `dac_cs_n` rises at E0 + 34·`CLK_DIV`.
  - LDAC low from E0 + 34·`CLK_DIV` to E0 + 35·`CLK_DIV`.
  - IDLE at E0 + 36·`CLK_DIV`.
  - Next accept possible at E0 + 36·`CLK_DIV` + 1.
- **With `CLK_DIV` = 2:** CS low for 68 cycles, IDLE at E72, back-to-back frame period 73 cycles, about 164 ksample/s.
- **Outputs:** all SPI outputs are registered, so there are no combinational paths from inputs to pins. `sample_ready` is decoded from the state register.

## Configuration
- **`DAC_LDAC_PULSE_EN` defined:** the LDAC state exists and `dac_ldac_n` pulses as above.
- **`DAC_LDAC_PULSE_EN` undefined:**
  - The LDAC state is removed and HOLD goes directly to GAP.
  - `dac_ldac_n` is held 0 permanently, including in reset; the DAC updates on the CS rise.
  - Sequence becomes: IDLE at E0 + 35·`CLK_DIV`, next accept at +1 (71 cycles at `CLK_DIV` = 2).

## Test plan
- **Single frame:** `CLK_DIV` = 2, `sample` = 0xABC, one-cycle valid → MOSI captured on 16 SCLK rises = 0x3ABC; CS low for exactly 68 cycles; LDAC low for 2 cycles after CS rises; ready again at E72.
- **Back-to-back:** `sample_valid` held high with 0x000 then 0xFFF → frames 0x3000 and 0x3FFF; CS falls 73 cycles apart; each sample accepted exactly once.
- **Valid while busy:** pulse valid with 0x555 at E10 during a frame → ignored; no extra frame; the next frame contains the next held sample only.
- **Reset mid-frame:** assert `rst_n` low at the 8th SCLK rise → outputs take reset values in the same cycle; after release, `sample_ready` = 1 and a new 0x123 frame is emitted intact as 0x3123.
- **Minimum divider:** `CLK_DIV` = 1, `sample` = 0x800 → SCLK = 6 MHz; CS low for 34 cycles; MOSI = 0x3800.
- **Macro off:** `DAC_LDAC_PULSE_EN` undefined → `dac_ldac_n` constantly 0; back-to-back period 71 cycles at `CLK_DIV` = 2.
